mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Parametrised MEM stage of the 5-stage in-order pipeline, between EX and WB.
- Adds split-transaction data-memory responses (data_ok), sub-word load extraction with sign/zero extension, and a one-entry response buffer.
- Adds flush with cancellation of in-flight responses, and a forwarding bus that marks a load result as not yet available.

Parameters:
- XLEN, 32, datapath and memory data width (32 or 64).
- DEST_W, 5, register-index width.
- CANCEL_W, 2, width of the cancelled-response counter; maximum count is 2^CANCEL_W-1.

Ports:
- clk  in  1  clock.
- reset  in  1  sync, active-high.
- flush  in  1  exception/ertn flush; kills the MS instruction.
- es_to_ms_valid  in  1  EX holds a valid instruction.
- ms_allow_in  out  1  MS accepts from EX this cycle.
- es_pc  in  XLEN  instruction PC.
- es_gr_we  in  1  register write enable.
- es_dest  in  DEST_W  destination register.
- es_alu_result  in  XLEN  ALU result, or byte address for memory operations.
- es_mem_op  in  3  MOP_NONE/LB/LH/LW/LBU/LHU/STORE (LD for XLEN=64 reuses LW code).
- es_mem_req  in  1  EX issued a data request for this instruction.
- data_sram_data_ok  in  1  one in-order response per request.
- data_sram_rdata  in  XLEN  read data, valid with data_ok.
- ws_allow_in  in  1  WB accepts.
- ms_to_ws_valid  out  1  valid to WB.
- ms_pc  out  XLEN  PC to WB.
- ms_gr_we  out  1  write enable to WB.
- ms_dest  out  DEST_W  destination to WB.
- ms_result  out  XLEN  final result to WB.
- fwd_we  out  1  ms_valid & ms_gr_we.
- fwd_dest  out  DEST_W  forwarding destination.
- fwd_data  out  XLEN  forwarding data.
- fwd_data_ok  out  1  fwd_data is final; 0 while a load awaits data_ok, so ID must stall.

Behaviour:
- Reset: ms_valid=0, buf_valid=0, cancel_cnt=0.
  - Consequently ms_to_ws_valid=0, fwd_we=0, ms_allow_in=1.
- Capture: when es_to_ms_valid & ms_allow_in & !flush, latch all es_* fields and set ms_valid=1.
- ms_valid update:
  - When ms_allow_in and no capture, ms_valid <= 0.
  - flush forces ms_valid <= 0 with priority over capture.
- resp_here = data_sram_data_ok & (cancel_cnt==0).
  - Responses always retire cancelled entries first (in-order).
- got_resp = buf_valid | resp_here.
- ms_ready_go = !ms_mem_req | got_resp.
- ms_allow_in = !ms_valid | (ms_ready_go & ws_allow_in).
- ms_to_ws_valid = ms_valid & ms_ready_go & !flush.
- Response buffer:
  - If resp_here & ms_valid & ms_mem_req & !buf_valid & !(ws_allow_in & ms_ready_go), latch rdata and set buf_valid.
  - buf_valid clears when MS hands off to WB or on flush.
- Raw data = buf_valid ? rdata_buf : data_sram_rdata.
  - Combinational bypass: a same-cycle response reaches WB with zero extra latency.
- Load alignment, with lane = ms_alu_result[log2(XLEN/8)-1:0]:
  - LB/LBU: byte at lane*8.
  - LH/LHU: halfword at lane[..:1]*16.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
  - Misaligned addresses never arrive (EX raises ALE).
- ms_result:
  - res_from_mem (LB..LHU, LW) ? aligned data : ms_alu_result.
  - STORE with gr_we=0: result is don't-care.
- Forwarding:
  - fwd_data = ms_result.
  - fwd_data_ok = !(ms_valid & ms_mem_req & is_load & !got_resp).
- Latency: 1 cycle for non-memory ops; 1+N cycles for memory ops, where N is the cycles until data_ok.
- Cancellation, at flush:
  - Add 1 if ms_valid & ms_mem_req & !got_resp.
  - Add 1 if es_to_ms_valid & es_mem_req (request already issued).
  - Each data_ok while cancel_cnt>0 decrements the counter and is dropped (no buffer write).
  - Increment and decrement may occur in the same cycle; apply the net change.
  - Count saturates at the maximum; an overflow assertion fires in simulation.
- While cancel_cnt>0, a new memory instruction may enter MS; it waits until its own response passes the counter.
- Stores wait for their write data_ok the same way as loads.

Decomposition:
- Package mem_pkg: MOP_* 3-bit encodings, is_load/is_store helper functions, XLEN-derived lane width constant.
- Sub-module load_align (combinational): inputs mem_op, addr lane, raw data; output extended XLEN value.
- The stage instantiates one load_align.

Test Plan:
- ADD, alu_result=0x1234, no req, ws_allow_in=1 -> next cycle ms_to_ws_valid=1, ms_result=0x1234, fwd_data_ok=1.
- LB at addr 0x...03, data_ok arrives 3 cycles late with rdata=0x80FF0000 -> fwd_data_ok=0 for 3 cycles, then ms_result=0xFFFFFF80. LBU same -> 0x00000080.
- LH at lane 2 with rdata=0x8001_0000, ws_allow_in=0 while data_ok pulses -> buf_valid=1. Releasing ws_allow_in two cycles later -> ms_result=0xFFFF8001 from the buffer, buf_valid clears.
- Load pending in MS and EX issued a load, then flush -> cancel_cnt=2. Two data_ok pulses (rdata 0xAA, 0xBB) are dropped. A next load's data_ok (rdata 0x55) delivers ms_result=0x55.
- flush coincident with data_ok for the MS load -> cancel_cnt stays 0, ms_valid=0, nothing sent to WB.
- reset asserted mid-wait, with buf_valid=1 and cancel_cnt=1 -> next cycle all three state registers are 0, ms_allow_in=1, ms_to_ws_valid=0.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: memory-op encodings and helpers shared by the MEM stage
package mem_pkg;

    typedef enum logic [2:0] {
        MOP_NONE  = 3'd0,
        MOP_LB    = 3'd1,
        MOP_LH    = 3'd2,
        MOP_LW    = 3'd3,
        MOP_LBU   = 3'd4,
        MOP_LHU   = 3'd5,
        MOP_STORE = 3'd6
    } mop_e;

    function automatic logic is_load(input logic [2:0] op);
        return op inside {MOP_LB, MOP_LH, MOP_LW, MOP_LBU, MOP_LHU};
    endfunction

    function automatic logic is_store(input logic [2:0] op);
        return op == MOP_STORE;
    endfunction

    function automatic int lane_w(input int xlen);
        return $clog2(xlen / 8);
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: selects the addressed byte/halfword of a load and extends it to XLEN
module load_align
    import mem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int LANE_W = lane_w(XLEN)
) (
    input  logic [2:0]        mem_op,
    input  logic [LANE_W-1:0] lane,
    input  logic [XLEN-1:0]   raw,
    output logic [XLEN-1:0]   data
);

    logic [7:0]  b;
    logic [15:0] h;

    // pick the lane and sign/zero extend; LW (and LD) passes the full word
    always_comb begin
        b    = raw[{lane, 3'b000} +: 8];
        h    = raw[{lane[LANE_W-1:1], 4'b0000} +: 16];
        data = mem_op == MOP_LB  ? {{(XLEN-8){b[7]}}, b}   :
               mem_op == MOP_LBU ? {{(XLEN-8){1'b0}}, b}   :
               mem_op == MOP_LH  ? {{(XLEN-16){h[15]}}, h} :
               mem_op == MOP_LHU ? {{(XLEN-16){1'b0}}, h}  : raw;
    end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage with split data responses, response buffer and flush cancellation
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DEST_W   = 5,
    parameter int CANCEL_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              es_to_ms_valid,
    output logic              ms_allow_in,
    input  logic [XLEN-1:0]   es_pc,
    input  logic              es_gr_we,
    input  logic [DEST_W-1:0] es_dest,
    input  logic [XLEN-1:0]   es_alu_result,
    input  logic [2:0]        es_mem_op,
    input  logic              es_mem_req,
    input  logic              data_sram_data_ok,
    input  logic [XLEN-1:0]   data_sram_rdata,
    input  logic              ws_allow_in,
    output logic              ms_to_ws_valid,
    output logic [XLEN-1:0]   ms_pc,
    output logic              ms_gr_we,
    output logic [DEST_W-1:0] ms_dest,
    output logic [XLEN-1:0]   ms_result,
    output logic              fwd_we,
    output logic [DEST_W-1:0] fwd_dest,
    output logic [XLEN-1:0]   fwd_data,
    output logic              fwd_data_ok
);

    localparam int                LANE_W = lane_w(XLEN);
    localparam logic [CANCEL_W:0] CMAX   = {1'b0, {CANCEL_W{1'b1}}};

    logic                ms_valid, ms_mem_req, buf_valid;
    logic [XLEN-1:0]     ms_alu_result, rdata_buf, raw, aligned;
    logic [2:0]          ms_mem_op;
    logic [CANCEL_W-1:0] cancel_cnt;
    logic [CANCEL_W:0]   cnt_sum;
    logic [1:0]          inc;
    logic                resp_here, got_resp, ms_ready_go, capture, handoff, ms_load, buf_set;

    load_align #(.XLEN(XLEN), .LANE_W(LANE_W)) u_align (
        .mem_op (ms_mem_op),
        .lane   (ms_alu_result[LANE_W-1:0]),
        .raw    (raw),
        .data   (aligned)
    );

    // handshake, result selection, forwarding and cancel-count arithmetic
    always_comb begin
        resp_here      = data_sram_data_ok & (cancel_cnt == '0);
        got_resp       = buf_valid | resp_here;
        ms_ready_go    = !ms_mem_req | got_resp;
        ms_allow_in    = !ms_valid | (ms_ready_go & ws_allow_in);
        ms_to_ws_valid = ms_valid & ms_ready_go & !flush;
        capture        = es_to_ms_valid & ms_allow_in & !flush;
        handoff        = ms_valid & ms_ready_go & ws_allow_in;
        buf_set        = resp_here & ms_valid & ms_mem_req & !buf_valid;
        ms_load        = is_load(ms_mem_op);
        raw            = buf_valid ? rdata_buf : data_sram_rdata;
        ms_result      = ms_load ? aligned : ms_alu_result;
        fwd_we         = ms_valid & ms_gr_we;
        fwd_dest       = ms_dest;
        fwd_data       = ms_result;
        fwd_data_ok    = !(ms_valid & ms_mem_req & ms_load & !got_resp);
        inc            = flush ? {1'b0, ms_valid & ms_mem_req & !got_resp} + {1'b0, es_to_ms_valid & es_mem_req} : 2'd0;
        cnt_sum        = {1'b0, cancel_cnt} + (CANCEL_W+1)'(inc) - (CANCEL_W+1)'(data_sram_data_ok & !resp_here);
    end

    // control state: valid bit, response-buffer flag, saturating cancelled-response count
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid   <= 1'b0;
            buf_valid  <= 1'b0;
            cancel_cnt <= '0;
        end else begin
            ms_valid   <= flush ? 1'b0 : capture ? 1'b1 : ms_allow_in ? 1'b0 : ms_valid;
            buf_valid  <= (flush | handoff) ? 1'b0 : buf_set ? 1'b1 : buf_valid;
            cancel_cnt <= cnt_sum > CMAX ? CMAX[CANCEL_W-1:0] : cnt_sum[CANCEL_W-1:0];
        end
    end

    // instruction fields from EX and the parked response word
    always_ff @(posedge clk) begin
        if (capture) begin
            ms_pc         <= es_pc;
            ms_gr_we      <= es_gr_we;
            ms_dest       <= es_dest;
            ms_alu_result <= es_alu_result;
            ms_mem_op     <= es_mem_op;
            ms_mem_req    <= es_mem_req;
        end
        if (buf_set) rdata_buf <= data_sram_rdata;
    end

    // more outstanding cancelled responses than the counter can hold
    always_ff @(posedge clk) begin
        if (!reset) assert (cnt_sum <= CMAX) else $error("cancel_cnt overflow");
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: directed stimulus with a per-cycle behavioural model of the MEM stage
module tb_mem_access_stage;
    import mem_pkg::*;

    logic        clk = 0, reset = 1, flush = 0, es_to_ms_valid = 0, es_gr_we = 0, es_mem_req = 0;
    logic        data_sram_data_ok = 0, ws_allow_in = 1;
    logic [31:0] es_pc = 0, es_alu_result = 0, data_sram_rdata = 0;
    logic [4:0]  es_dest = 0;
    logic [2:0]  es_mem_op = 0;
    logic        ms_allow_in, ms_to_ws_valid, ms_gr_we, fwd_we, fwd_data_ok;
    logic [31:0] ms_pc, ms_result, fwd_data;
    logic [4:0]  ms_dest, fwd_dest;
    int          checks = 0, failures = 0;
    bit          go = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.XLEN(32), .DEST_W(5), .CANCEL_W(2)) dut (
        .clk(clk), .reset(reset), .flush(flush), .es_to_ms_valid(es_to_ms_valid), .ms_allow_in(ms_allow_in),
        .es_pc(es_pc), .es_gr_we(es_gr_we), .es_dest(es_dest), .es_alu_result(es_alu_result),
        .es_mem_op(es_mem_op), .es_mem_req(es_mem_req), .data_sram_data_ok(data_sram_data_ok),
        .data_sram_rdata(data_sram_rdata), .ws_allow_in(ws_allow_in), .ms_to_ws_valid(ms_to_ws_valid),
        .ms_pc(ms_pc), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest), .ms_result(ms_result), .fwd_we(fwd_we),
        .fwd_dest(fwd_dest), .fwd_data(fwd_data), .fwd_data_ok(fwd_data_ok)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit ld(input logic [2:0] op);
        return op >= 3'd1 && op <= 3'd5;
    endfunction

    function automatic logic [31:0] ext(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] d);
        int lane;
        logic [31:0] b, h;
        lane = int'(addr % 4);
        b = (d >> (8 * lane)) & 32'hFF;
        h = (d >> (16 * (lane / 2))) & 32'hFFFF;
        case (op)
            MOP_LB:  return b >= 32'h80 ? b + 32'hFFFFFF00 : b;
            MOP_LBU: return b;
            MOP_LH:  return h >= 32'h8000 ? h + 32'hFFFF0000 : h;
            MOP_LHU: return h;
            default: return d;
        endcase
    endfunction

    bit          mv = 0, mwe = 0, mreq = 0, hv = 0;
    logic [31:0] mpc = 0, malu = 0, md = 0;
    logic [4:0]  mdest = 0;
    logic [2:0]  mop = 0;
    int          drop = 0;

    initial begin
        bit got, resp, rdy, allow, tows, fok;
        int inc, dec;
        logic [31:0] res;
        wait (go);
        forever begin
            @(negedge clk);
            resp  = data_sram_data_ok && drop == 0;
            got   = hv || resp;
            rdy   = !mreq || got;
            allow = !mv || (rdy && ws_allow_in);
            tows  = mv && rdy && !flush;
            fok   = !(mv && mreq && ld(mop) && !got);
            res   = ld(mop) ? ext(mop, malu, hv ? md : data_sram_rdata) : malu;
            chk("m_allow_in", 32'(ms_allow_in), 32'(allow));
            chk("m_to_ws_valid", 32'(ms_to_ws_valid), 32'(tows));
            chk("m_fwd_we", 32'(fwd_we), 32'(mv && mwe));
            chk("m_cancel_cnt", 32'(dut.cancel_cnt), 32'(drop));
            chk("m_buf_valid", 32'(dut.buf_valid), 32'(hv));
            if (tows) begin
                chk("m_pc", ms_pc, mpc);
                chk("m_dest", 32'(ms_dest), 32'(mdest));
                chk("m_gr_we", 32'(ms_gr_we), 32'(mwe));
                if (mop != MOP_STORE) chk("m_result", ms_result, res);
            end
            if (mv && mwe) begin
                chk("m_fwd_dest", 32'(fwd_dest), 32'(mdest));
                chk("m_fwd_data_ok", 32'(fwd_data_ok), 32'(fok));
                if (fok) chk("m_fwd_data", fwd_data, res);
            end
            if (reset) begin
                mv = 0; hv = 0; drop = 0;
            end else begin
                inc  = flush ? int'(mv && mreq && !got) + int'(es_to_ms_valid && es_mem_req) : 0;
                dec  = int'(data_sram_data_ok && drop > 0);
                drop = drop + inc - dec;
                if (drop > 3) drop = 3;
                if (flush || (mv && rdy && ws_allow_in)) hv = 0;
                else if (mv && mreq && resp && !hv) begin hv = 1; md = data_sram_rdata; end
                if (flush) mv = 0;
                else if (es_to_ms_valid && allow) begin
                    mv = 1; mpc = es_pc; mwe = es_gr_we; mdest = es_dest;
                    malu = es_alu_result; mop = es_mem_op; mreq = es_mem_req;
                end else if (allow) mv = 0;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        es_to_ms_valid = 0; es_mem_req = 0; flush = 0; data_sram_data_ok = 0;
    endtask

    task automatic gap;
        tick; idle; ws_allow_in = 1; data_sram_rdata = 0; reset = 0;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] alu, input logic req, input logic [4:0] dest);
        es_to_ms_valid = 1; es_mem_op = op; es_alu_result = alu; es_mem_req = req;
        es_dest = dest; es_gr_we = op != MOP_STORE; es_pc = alu + 32'h1000;
    endtask

    task automatic load_late(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rd,
                             input logic [31:0] exp, input string name);
        gap; tick; issue(op, addr, 1, 4);
        tick; idle;
        for (int i = 0; i < 3; i++) begin
            #1 chk({name, "_wait_fok"}, 32'(fwd_data_ok), 0);
            chk({name, "_wait_allow"}, 32'(ms_allow_in), 0);
            tick;
        end
        data_sram_data_ok = 1; data_sram_rdata = rd;
        #1 chk({name, "_valid"}, 32'(ms_to_ws_valid), 1);
        chk({name, "_result"}, ms_result, exp);
        chk({name, "_fok"}, 32'(fwd_data_ok), 1);
    endtask

    initial begin
        tick; go = 1;
        #1 chk("rst_allow", 32'(ms_allow_in), 1);
        chk("rst_to_ws", 32'(ms_to_ws_valid), 0);
        chk("rst_fwd_we", 32'(fwd_we), 0);
        gap;
        tick; issue(MOP_NONE, 32'h1234, 0, 3);
        #1 chk("add_allow", 32'(ms_allow_in), 1);
        tick; idle;
        #1 chk("add_valid", 32'(ms_to_ws_valid), 1);
        chk("add_result", ms_result, 32'h1234);
        chk("add_fok", 32'(fwd_data_ok), 1);
        load_late(MOP_LB, 32'h1003, 32'h80FF0000, 32'hFFFFFF80, "lb");
        load_late(MOP_LBU, 32'h1003, 32'h80FF0000, 32'h00000080, "lbu");
        gap; tick; issue(MOP_LH, 32'h2002, 1, 5);
        tick; idle; ws_allow_in = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h80010000;
        #1 chk("lh_offer", 32'(ms_to_ws_valid), 1);
        chk("lh_allow", 32'(ms_allow_in), 0);
        tick; data_sram_data_ok = 0; data_sram_rdata = 32'hDEADBEEF;
        #1 chk("lh_buf", 32'(dut.buf_valid), 1);
        chk("lh_buf_result", ms_result, 32'hFFFF8001);
        tick; ws_allow_in = 1;
        #1 chk("lh_rel_result", ms_result, 32'hFFFF8001);
        chk("lh_rel_valid", 32'(ms_to_ws_valid), 1);
        tick;
        #1 chk("lh_buf_clr", 32'(dut.buf_valid), 0);
        gap; tick; issue(MOP_LW, 32'h3000, 1, 6);
        tick; issue(MOP_LW, 32'h3004, 1, 7);
        #1 chk("c_allow", 32'(ms_allow_in), 0);
        tick; flush = 1;
        #1 chk("c_flush_to_ws", 32'(ms_to_ws_valid), 0);
        tick; idle;
        #1 chk("c_cnt2", 32'(dut.cancel_cnt), 2);
        chk("c_ms_valid", 32'(dut.ms_valid), 0);
        data_sram_data_ok = 1; data_sram_rdata = 32'hAA; issue(MOP_LW, 32'h3008, 1, 8);
        tick; idle; data_sram_data_ok = 1; data_sram_rdata = 32'hBB;
        #1 chk("c_cnt1", 32'(dut.cancel_cnt), 1);
        chk("c_drop_fok", 32'(fwd_data_ok), 0);
        chk("c_drop_to_ws", 32'(ms_to_ws_valid), 0);
        tick; data_sram_data_ok = 1; data_sram_rdata = 32'h55;
        #1 chk("c_cnt0", 32'(dut.cancel_cnt), 0);
        chk("c_result", ms_result, 32'h55);
        chk("c_to_ws", 32'(ms_to_ws_valid), 1);
        gap; tick; issue(MOP_LW, 32'h4000, 1, 9);
        tick; idle; data_sram_data_ok = 1; data_sram_rdata = 32'h77; flush = 1;
        #1 chk("f_to_ws", 32'(ms_to_ws_valid), 0);
        tick; idle;
        #1 chk("f_cnt", 32'(dut.cancel_cnt), 0);
        chk("f_ms_valid", 32'(dut.ms_valid), 0);
        chk("f_to_ws_after", 32'(ms_to_ws_valid), 0);
        gap; tick; issue(MOP_STORE, 32'h5000, 1, 0);
        tick; idle;
        #1 chk("st_wait_allow", 32'(ms_allow_in), 0);
        chk("st_fwd_we", 32'(fwd_we), 0);
        tick; data_sram_data_ok = 1;
        #1 chk("st_done", 32'(ms_to_ws_valid), 1);
        gap; tick; issue(MOP_LW, 32'h6000, 1, 10);
        tick; idle; ws_allow_in = 0; data_sram_data_ok = 1; data_sram_rdata = 32'h99;
        tick; data_sram_data_ok = 0; reset = 1;
        #1 chk("r1_buf_pre", 32'(dut.buf_valid), 1);
        tick; reset = 0; ws_allow_in = 1;
        #1 chk("r1_ms_valid", 32'(dut.ms_valid), 0);
        chk("r1_buf", 32'(dut.buf_valid), 0);
        chk("r1_allow", 32'(ms_allow_in), 1);
        gap; tick; issue(MOP_LW, 32'h7000, 1, 11);
        tick; idle; flush = 1;
        tick; idle;
        #1 chk("r2_cnt_pre", 32'(dut.cancel_cnt), 1);
        issue(MOP_LW, 32'h7004, 1, 12);
        tick; idle; reset = 1;
        #1 chk("r2_ms_valid_pre", 32'(dut.ms_valid), 1);
        tick; reset = 0;
        #1 chk("r2_cnt", 32'(dut.cancel_cnt), 0);
        chk("r2_ms_valid", 32'(dut.ms_valid), 0);
        chk("r2_buf", 32'(dut.buf_valid), 0);
        chk("r2_allow", 32'(ms_allow_in), 1);
        chk("r2_to_ws", 32'(ms_to_ws_valid), 0);
        gap; tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
